pcie_dllp_tx_scheduler: RTL
===========================

PCIE_DLLP_TX_SCHEDULER -- requirements
Module: pcie_dllp_tx_scheduler

Interface
REQ-001 SHALL have parameter ACK_LAT_LIMIT, default 64, meaning cycles an Ack may stay pending before it is forced out.
REQ-002 SHALL have parameter ACK_COALESCE, default 4, meaning the number of coalesced Ack requests that forces an immediate Ack.
REQ-003 SHALL have parameter FC_UPDATE_PERIOD, default 1024, meaning cycles between periodic UpdateFC DLLPs.
REQ-004 Ports, one per line (name, direction, width, meaning):
- clk  in  1  clock; reset is asynchronous and active-high on the next line
- rst  in  1  asynchronous, active-high reset
- ack_req_i  in  1  one-cycle pulse: good TLP accepted
- nak_req_i  in  1  one-cycle pulse: bad or out-of-order TLP
- seq_num_i  in  12  sequence number carried by the Ack or Nak request
- fc_update_i  in  1  one-cycle pulse: receive credits changed
- fc_credit_i  in  12  current advertised credit value
- dllp_valid_o  out  1  DLLP valid to PHY
- dllp_o  out  PCIe_PKG::dllp_tx_packet  outgoing DLLP (type[7:0], payload[11:0])
- dllp_ready_i  in  1  PHY accepts the DLLP
- nak_scheduled_o  out  1  a Nak has been issued and no good TLP has arrived since

Function
REQ-005 SHALL implement a two-state FSM, IDLE and SEND; dllp_valid_o=1 exactly in SEND.
REQ-006 In IDLE, if any source is due, the block SHALL load dllp_o and enter SEND on the next edge.
REQ-007 In SEND, when dllp_ready_i=1 the block SHALL return to IDLE; this gives at most one DLLP per 2 cycles.
REQ-008 While in SEND with dllp_ready_i=0, dllp_o SHALL be held stable.
REQ-009 On ack_req_i, the block SHALL set ack_pend, set ack_seq=seq_num_i, increment ack_cnt (saturating at ACK_COALESCE) and clear nak_scheduled.
REQ-010 On nak_req_i with nak_scheduled=0, the block SHALL set nak_pend, set nak_seq=seq_num_i and set nak_scheduled; nak_req_i with nak_scheduled=1 SHALL be ignored.
REQ-011 When ack_req_i and nak_req_i are asserted in the same cycle, the Nak SHALL win and the Ack request SHALL be dropped.
REQ-012 ack_timer SHALL count while ack_pend=1 and saturate; Ack is due when ack_timer>=ACK_LAT_LIMIT-1 or ack_cnt>=ACK_COALESCE.
REQ-013 fc_timer SHALL free-run; fc_pend SHALL be set by fc_update_i or by fc_timer==FC_UPDATE_PERIOD-1; FC is due when fc_pend=1.
REQ-014 Arbitration priority SHALL be Nak > Ack-due > FC-due, except that FC-due SHALL beat Ack-due when the last grant was an Ack.
REQ-015 Nak load SHALL produce type=DLLP_NAK (8'h10), payload=nak_seq; it SHALL clear nak_pend, ack_pend, ack_cnt and ack_timer.
REQ-016 Ack load SHALL produce type=DLLP_ACK (8'h00), payload=ack_seq; it SHALL clear ack_pend, ack_cnt and ack_timer.
REQ-017 FC load SHALL produce type=DLLP_UPDATEFC (8'h80), payload=fc_credit_i sampled at load; it SHALL clear fc_pend and fc_timer.
REQ-018 A request arriving in the same cycle as the clear of its source SHALL win: the source stays pending with new data and its count is 1.
REQ-019 Requests arriving during SEND SHALL be captured into pending state and never lost, except as stated in REQ-010 and REQ-011.
REQ-020 All counters SHALL be $clog2(parameter)+1 bits wide; sequence and credit arithmetic SHALL wrap modulo 4096.

Reset
REQ-021 rst SHALL asynchronously force: FSM=IDLE, dllp_valid_o=0, dllp_o=0, nak_scheduled_o=0, all pend flags, counters and timers=0, last-grant=FC.
REQ-022 Reset asserted during SEND SHALL drop dllp_valid_o in the same cycle without waiting for a clock edge; the pending DLLP is discarded.

Structure
REQ-023 PCIe_PKG SHALL hold dllp_tx_packet and the constants DLLP_ACK, DLLP_NAK and DLLP_UPDATEFC.
REQ-024 The block SHALL be a single module with no sub-modules; the arbiter is inline combinational logic feeding the FSM.

Verification
REQ-025 4 ack_req_i pulses, seq 1..4, dllp_ready_i=1 -> exactly one Ack DLLP, payload 4, dllp_valid_o within 2 cycles of the 4th pulse.
REQ-026 Single ack_req_i, seq 7 -> Ack DLLP with payload 7 appears 64 cycles later; no DLLP appears earlier.
REQ-027 nak_req_i seq 9, then nak_req_i seq 10 -> one Nak DLLP with payload 9; nak_scheduled_o stays 1 until the next ack_req_i, then returns to 0.
REQ-028 fc_update_i with fc_credit_i=12'h123 and dllp_ready_i=0 for 10 cycles -> dllp_o={8'h80,12'h123} held stable all 10 cycles, handshake on ready.
REQ-029 Ack-due and FC-due pending together after an Ack grant -> UpdateFC is sent first, then the Ack.
REQ-030 rst pulsed during SEND -> dllp_valid_o=0 immediately; after release, no DLLP is sent until a new request arrives.

Source files
------------

// File: rtl/PCIe_PKG.sv
// Shared DLLP transmit types: packet layout, DLLP type codes and scheduler enums.
package PCIe_PKG;

  localparam logic [7:0] DLLP_ACK      = 8'h00;
  localparam logic [7:0] DLLP_NAK      = 8'h10;
  localparam logic [7:0] DLLP_UPDATEFC = 8'h80;

  typedef struct packed {
    logic [7:0]  dllp_type;
    logic [11:0] payload;
  } dllp_tx_packet;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } tx_state_e;

  typedef enum logic [1:0] {
    GNT_FC,
    GNT_ACK,
    GNT_NAK
  } grant_e;

endpackage

// File: rtl/pcie_dllp_tx_scheduler.sv
// DLLP transmit scheduler: coalesces Ack/Nak requests, generates UpdateFC
// DLLPs and arbitrates them onto a single valid/ready link to the PHY.
module pcie_dllp_tx_scheduler
  import PCIe_PKG::*;
#(
  parameter int ACK_LAT_LIMIT    = 64,
  parameter int ACK_COALESCE     = 4,
  parameter int FC_UPDATE_PERIOD = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ack_req_i,
  input  logic          nak_req_i,
  input  logic [11:0]   seq_num_i,
  input  logic          fc_update_i,
  input  logic [11:0]   fc_credit_i,
  output logic          dllp_valid_o,
  output dllp_tx_packet dllp_o,
  input  logic          dllp_ready_i,
  output logic          nak_scheduled_o
);

  localparam int ACK_TMR_W = $clog2(ACK_LAT_LIMIT) + 1;
  localparam int ACK_CNT_W = $clog2(ACK_COALESCE) + 1;
  localparam int FC_TMR_W  = $clog2(FC_UPDATE_PERIOD) + 1;

  localparam logic [ACK_TMR_W-1:0] ACK_TMR_DUE = ACK_TMR_W'(ACK_LAT_LIMIT - 1);
  localparam logic [ACK_CNT_W-1:0] ACK_CNT_MAX = ACK_CNT_W'(ACK_COALESCE);
  localparam logic [FC_TMR_W-1:0]  FC_TMR_WRAP = FC_TMR_W'(FC_UPDATE_PERIOD - 1);

  tx_state_e               state_q, state_d;
  grant_e                  last_grant_q, last_grant_d;
  dllp_tx_packet           dllp_q, dllp_d;
  logic                    ack_pend_q, ack_pend_d;
  logic [11:0]             ack_seq_q, ack_seq_d;
  logic [ACK_CNT_W-1:0]    ack_cnt_q, ack_cnt_d;
  logic [ACK_TMR_W-1:0]    ack_timer_q, ack_timer_d;
  logic                    nak_pend_q, nak_pend_d;
  logic [11:0]             nak_seq_q, nak_seq_d;
  logic                    nak_sched_q, nak_sched_d;
  logic                    fc_pend_q, fc_pend_d;
  logic [FC_TMR_W-1:0]     fc_timer_q, fc_timer_d;

  logic   ack_take, nak_take, ack_due, fc_due, fc_wrap, any_due;
  logic   load, load_nak, load_ack, load_fc;
  grant_e grant_sel;

  // A simultaneous Nak suppresses the Ack; a repeat Nak is ignored until an Ack clears it.
  assign ack_take = ack_req_i & ~nak_req_i;
  assign nak_take = nak_req_i & ~nak_sched_q;
  assign ack_due  = ack_pend_q & ((ack_timer_q >= ACK_TMR_DUE) | (ack_cnt_q >= ACK_CNT_MAX));
  assign fc_due   = fc_pend_q;
  assign fc_wrap  = (fc_timer_q == FC_TMR_WRAP);
  assign any_due  = nak_pend_q | ack_due | fc_due;

  always_comb begin
    grant_sel = GNT_FC;
    if (nak_pend_q) begin
      grant_sel = GNT_NAK;
    end else if (ack_due && !(fc_due && last_grant_q == GNT_ACK)) begin
      grant_sel = GNT_ACK;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    dllp_d       = dllp_q;
    load         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_due) begin
          load         = 1'b1;
          state_d      = ST_SEND;
          last_grant_d = grant_sel;
          case (grant_sel)
            GNT_NAK: dllp_d = '{dllp_type: DLLP_NAK, payload: nak_seq_q};
            GNT_ACK: dllp_d = '{dllp_type: DLLP_ACK, payload: ack_seq_q};
            default: dllp_d = '{dllp_type: DLLP_UPDATEFC, payload: fc_credit_i};
          endcase
        end
      end
      default: begin
        if (dllp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  assign load_nak = load & (grant_sel == GNT_NAK);
  assign load_ack = load & (grant_sel == GNT_ACK);
  assign load_fc  = load & (grant_sel == GNT_FC);

  // Clears from a load are applied first so a same-cycle request overrides them.
  always_comb begin
    ack_pend_d  = ack_pend_q;
    ack_seq_d   = ack_seq_q;
    ack_cnt_d   = ack_cnt_q;
    ack_timer_d = ack_timer_q;
    nak_pend_d  = nak_pend_q;
    nak_seq_d   = nak_seq_q;
    nak_sched_d = nak_sched_q;
    fc_pend_d   = fc_pend_q;
    fc_timer_d  = fc_timer_q + FC_TMR_W'(1);

    if (ack_pend_q && ack_timer_q != '1) begin
      ack_timer_d = ack_timer_q + ACK_TMR_W'(1);
    end
    if (load_nak || load_ack) begin
      ack_pend_d  = 1'b0;
      ack_cnt_d   = '0;
      ack_timer_d = '0;
    end
    if (load_nak) begin
      nak_pend_d = 1'b0;
    end
    if (load_fc) begin
      fc_pend_d = 1'b0;
    end
    if (load_fc || fc_wrap) begin
      fc_timer_d = '0;
    end

    if (ack_take) begin
      ack_pend_d  = 1'b1;
      ack_seq_d   = seq_num_i;
      nak_sched_d = 1'b0;
      if (ack_cnt_d < ACK_CNT_MAX) begin
        ack_cnt_d = ack_cnt_d + ACK_CNT_W'(1);
      end
    end
    if (nak_take) begin
      nak_pend_d  = 1'b1;
      nak_seq_d   = seq_num_i;
      nak_sched_d = 1'b1;
    end
    if (fc_update_i || fc_wrap) begin
      fc_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GNT_FC;
      dllp_q       <= '0;
      ack_pend_q   <= 1'b0;
      ack_seq_q    <= '0;
      ack_cnt_q    <= '0;
      ack_timer_q  <= '0;
      nak_pend_q   <= 1'b0;
      nak_seq_q    <= '0;
      nak_sched_q  <= 1'b0;
      fc_pend_q    <= 1'b0;
      fc_timer_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      dllp_q       <= dllp_d;
      ack_pend_q   <= ack_pend_d;
      ack_seq_q    <= ack_seq_d;
      ack_cnt_q    <= ack_cnt_d;
      ack_timer_q  <= ack_timer_d;
      nak_pend_q   <= nak_pend_d;
      nak_seq_q    <= nak_seq_d;
      nak_sched_q  <= nak_sched_d;
      fc_pend_q    <= fc_pend_d;
      fc_timer_q   <= fc_timer_d;
    end
  end

  // Valid decodes straight from the state flop so reset removes it without a clock.
  assign dllp_valid_o    = (state_q == ST_SEND);
  assign dllp_o          = dllp_q;
  assign nak_scheduled_o = nak_sched_q;

endmodule
